// File: rtl/pmu_pwr_seq.sv
// Shut-domain power sequencer on the always-on 32 kHz clock.
// Orders oscillator enable, clock-gate enable and reset release on power-up,
// and the reverse on power-down. All outputs come straight from flops.
module pmu_pwr_seq #(
    parameter int unsigned OSC_WAIT = 8,
    parameter int unsigned RST_HOLD = 4,
    parameter int unsigned DRAIN    = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wake_req,
    input  logic       sleep_req,
    output logic       osc13m_en,
    output logic       clk_en,
    output logic       shut_rstn,
    output logic [2:0] pwr_state,
    output logic       busy,
    output logic       seq_done
);

    localparam logic [2:0] StOff    = 3'd0;
    localparam logic [2:0] StOscUp  = 3'd1;
    localparam logic [2:0] StClkOn  = 3'd2;
    localparam logic [2:0] StActive = 3'd3;
    localparam logic [2:0] StRstOn  = 3'd4;
    localparam logic [2:0] StClkOff = 3'd5;

    // Last count value of each timed state (dwell of N cycles ends at N-1).
    localparam logic [CNT_W-1:0] OscLast   = CNT_W'(OSC_WAIT - 1);
    localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] DrainLast = CNT_W'(DRAIN - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_on_q, tgt_on_d;
    logic             timed;
    logic             osc_d, clk_en_d, shut_rstn_d, busy_d, seq_done_d;

    // Target power state; wake wins over a simultaneous sleep.
    always_comb begin
        tgt_on_d = tgt_on_q;
        if (sleep_req) tgt_on_d = 1'b0;
        if (wake_req)  tgt_on_d = 1'b1;
    end

    // Next-state logic; sequences run to completion, tgt_on only acted on in stable states.
    always_comb begin
        state_d = state_q;
        timed   = 1'b0;
        case (state_q)
            StOff: begin
                if (tgt_on_d) state_d = StOscUp;
            end
            StOscUp: begin
                timed = 1'b1;
                if (cnt_q == OscLast) state_d = StClkOn;
            end
            StClkOn: begin
                timed = 1'b1;
                if (cnt_q == HoldLast) state_d = StActive;
            end
            StActive: begin
                if (!tgt_on_d) state_d = StRstOn;
            end
            StRstOn: begin
                timed = 1'b1;
                if (cnt_q == DrainLast) state_d = StClkOff;
            end
            StClkOff: begin
                state_d = StOff;
            end
            default: begin
                state_d = StOff;
            end
        endcase
    end

    // Shared delay counter: cleared on any state change, counts only in timed states.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (timed) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output values decoded from the next state so they land on the same edge as the state.
    always_comb begin
        osc_d       = 1'b0;
        clk_en_d    = 1'b0;
        shut_rstn_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            StOscUp:  begin osc_d = 1'b1; busy_d = 1'b1; end
            StClkOn:  begin osc_d = 1'b1; clk_en_d = 1'b1; busy_d = 1'b1; end
            StActive: begin osc_d = 1'b1; clk_en_d = 1'b1; shut_rstn_d = 1'b1; end
            StRstOn:  begin osc_d = 1'b1; clk_en_d = 1'b1; busy_d = 1'b1; end
            StClkOff: begin osc_d = 1'b1; busy_d = 1'b1; end
            default:  begin end
        endcase
        seq_done_d = (state_d != state_q) && ((state_d == StActive) || (state_d == StOff));
    end

    // State, counter, target and registered outputs; synchronous reset skips any power-down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StOff;
            cnt_q     <= '0;
            tgt_on_q  <= 1'b0;
            osc13m_en <= 1'b0;
            clk_en    <= 1'b0;
            shut_rstn <= 1'b0;
            busy      <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_on_q  <= tgt_on_d;
            osc13m_en <= osc_d;
            clk_en    <= clk_en_d;
            shut_rstn <= shut_rstn_d;
            busy      <= busy_d;
            seq_done  <= seq_done_d;
        end
    end

    assign pwr_state = state_q;

endmodule

// File: tb/tb_pmu_pwr_seq.sv
// Directed bench for pmu_pwr_seq: default-timing instance (a) and a
// minimum-timing instance (b), with an every-cycle ordering monitor.
module tb_pmu_pwr_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, wake_a = 1'b0, sleep_a = 1'b0;
    logic rst_b = 1'b1, wake_b = 1'b0, sleep_b = 1'b0;
    logic osc_a, clk_en_a, rstn_a, busy_a, done_a;
    logic osc_b, clk_en_b, rstn_b, busy_b, done_b;
    logic [2:0] st_a, st_b;

    pmu_pwr_seq u_dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .wake_req  (wake_a),
        .sleep_req (sleep_a),
        .osc13m_en (osc_a),
        .clk_en    (clk_en_a),
        .shut_rstn (rstn_a),
        .pwr_state (st_a),
        .busy      (busy_a),
        .seq_done  (done_a)
    );

    pmu_pwr_seq #(
        .OSC_WAIT (1),
        .RST_HOLD (1),
        .DRAIN    (1),
        .CNT_W    (8)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .wake_req  (wake_b),
        .sleep_req (sleep_b),
        .osc13m_en (osc_b),
        .clk_en    (clk_en_b),
        .shut_rstn (rstn_b),
        .pwr_state (st_b),
        .busy      (busy_b),
        .seq_done  (done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packed expectation {osc, clk_en, shut_rstn, busy, seq_done, state} from the state table.
    function automatic logic [7:0] exp_of(input int st, input bit done);
        logic osc, ce, rn, bz;
        osc = (st >= 1) && (st <= 5);
        ce  = (st >= 2) && (st <= 4);
        rn  = (st == 3);
        bz  = (st == 1) || (st == 2) || (st == 4) || (st == 5);
        return {osc, ce, rn, bz, done, 3'(st)};
    endfunction

    // Hand-derived state per cycle for each directed scenario.
    function automatic int exp_state(input int scen, input int c);
        case (scen)
            1: begin  // wake@0, sleep@20, defaults
                if (c >= 1 && c <= 8)   return 1;
                if (c >= 9 && c <= 12)  return 2;
                if (c >= 13 && c <= 20) return 3;
                if (c >= 21 && c <= 24) return 4;
                if (c == 25)            return 5;
                return 0;
            end
            3: begin  // sleep arrives mid power-up
                if (c >= 1 && c <= 8)   return 1;
                if (c >= 9 && c <= 12)  return 2;
                if (c == 13)            return 3;
                if (c >= 14 && c <= 17) return 4;
                if (c == 18)            return 5;
                return 0;
            end
            4: begin  // wake arrives during RST_ON
                if (c >= 1 && c <= 8)   return 1;
                if (c >= 9 && c <= 12)  return 2;
                if (c >= 13 && c <= 14) return 3;
                if (c >= 15 && c <= 18) return 4;
                if (c == 19)            return 5;
                if (c == 20)            return 0;
                if (c >= 21 && c <= 28) return 1;
                if (c >= 29 && c <= 32) return 2;
                if (c >= 33 && c <= 34) return 3;
                if (c >= 35 && c <= 38) return 4;
                if (c == 39)            return 5;
                return 0;
            end
            5: begin  // reset while in CLK_ON
                if (c >= 1 && c <= 8)  return 1;
                if (c >= 9 && c <= 10) return 2;
                return 0;
            end
            6: begin  // minimum timing instance
                if (c == 1)            return 1;
                if (c == 2)            return 2;
                if (c >= 3 && c <= 5)  return 3;
                if (c == 6)            return 4;
                if (c == 7)            return 5;
                return 0;
            end
            default: return 0;
        endcase
    endfunction

    // Drive one cycle's inputs, advance an edge, then compare the new cycle's outputs.
    task automatic cyc(input bit sel_b, input bit r, input bit w, input bit s,
                       input int exp_st, input bit exp_done, input string tag);
        logic [7:0] got;
        if (sel_b) begin
            rst_b = r; wake_b = w; sleep_b = s;
        end else begin
            rst_a = r; wake_a = w; sleep_a = s;
        end
        @(posedge clk);
        #1;
        rst_a = 1'b0; wake_a = 1'b0; sleep_a = 1'b0;
        rst_b = 1'b0; wake_b = 1'b0; sleep_b = 1'b0;
        got = sel_b ? {osc_b, clk_en_b, rstn_b, busy_b, done_b, st_b}
                    : {osc_a, clk_en_a, rstn_a, busy_a, done_a, st_a};
        check_eq(tag, {24'd0, got}, {24'd0, exp_of(exp_st, exp_done)});
    endtask

    // Ordering monitor; the change rule is skipped right after a reset edge.
    logic mon_on = 1'b0;
    logic rst_seen_a = 1'b1, rst_seen_b = 1'b1;
    logic posc_a, pce_a, prn_a, posc_b, pce_b, prn_b;

    always @(posedge clk) begin
        rst_seen_a <= rst_a;
        rst_seen_b <= rst_b;
    end

    task automatic mon_check(input string tag, input logic osc, input logic ce, input logic rn,
                             input logic [2:0] st, input logic bz, input logic posc,
                             input logic pce, input logic prn, input logic was_rst);
        check_eq({tag, " clk_en->osc"}, {31'd0, ce & ~osc}, 32'd0);
        check_eq({tag, " rstn->clk_en"}, {31'd0, rn & ~ce}, 32'd0);
        check_eq({tag, " busy"}, {31'd0, bz},
                 {31'd0, (st == 3'd1) || (st == 3'd2) || (st == 3'd4) || (st == 3'd5)});
        check_eq({tag, " legal state"}, {31'd0, st > 3'd5}, 32'd0);
        if (!was_rst) begin
            check_eq({tag, " clk_en change alone"},
                     {31'd0, (ce != pce) && ((rn != prn) || (osc != posc))}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon_check("mon_a", osc_a, clk_en_a, rstn_a, st_a, busy_a,
                      posc_a, pce_a, prn_a, rst_seen_a);
            mon_check("mon_b", osc_b, clk_en_b, rstn_b, st_b, busy_b,
                      posc_b, pce_b, prn_b, rst_seen_b);
        end
        posc_a <= osc_a; pce_a <= clk_en_a; prn_a <= rstn_a;
        posc_b <= osc_b; pce_b <= clk_en_b; prn_b <= rstn_b;
    end

    initial begin
        // Reset both instances with requests held to show they are ignored.
        wake_a = 1'b1; wake_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset a", {24'd0, osc_a, clk_en_a, rstn_a, busy_a, done_a, st_a}, 32'd0);
        check_eq("reset b", {24'd0, osc_b, clk_en_b, rstn_b, busy_b, done_b, st_b}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; wake_a = 1'b0; wake_b = 1'b0;
        mon_on = 1'b1;

        // Full power-up then power-down at default timing.
        for (int k = 0; k <= 28; k++) begin
            cyc(1'b0, 1'b0, k == 0, k == 20, exp_state(1, k + 1),
                (k + 1 == 13) || (k + 1 == 26), $sformatf("updown c%0d", k + 1));
        end

        // Sleep during power-up: ACTIVE for one cycle then power-down.
        for (int k = 0; k <= 19; k++) begin
            cyc(1'b0, 1'b0, k == 0, k == 3, exp_state(3, k + 1),
                (k + 1 == 13) || (k + 1 == 19), $sformatf("sleep_mid c%0d", k + 1));
        end

        // Wake during RST_ON: OFF for one cycle then power-up again.
        for (int k = 0; k <= 40; k++) begin
            cyc(1'b0, 1'b0, (k == 0) || (k == 16), (k == 14) || (k == 34), exp_state(4, k + 1),
                (k + 1 == 13) || (k + 1 == 20) || (k + 1 == 33) || (k + 1 == 40),
                $sformatf("wake_mid c%0d", k + 1));
        end

        // Wake and sleep together in OFF: wake wins; sleep in first ACTIVE cycle.
        for (int k = 0; k <= 19; k++) begin
            cyc(1'b0, 1'b0, k == 0, (k == 0) || (k == 13), exp_state(3, k + 1),
                (k + 1 == 13) || (k + 1 == 19), $sformatf("both_req c%0d", k + 1));
        end

        // Reset in CLK_ON with a wake in the same cycle: straight to OFF, no done, stays OFF.
        for (int k = 0; k <= 25; k++) begin
            cyc(1'b0, k == 10, (k == 0) || (k == 10), 1'b0, exp_state(5, k + 1), 1'b0,
                $sformatf("rst_clkon c%0d", k + 1));
        end

        // Minimum timing: three-cycle up and down sequences.
        for (int k = 0; k <= 9; k++) begin
            cyc(1'b1, 1'b0, k == 0, k == 5, exp_state(6, k + 1),
                (k + 1 == 3) || (k + 1 == 8), $sformatf("min c%0d", k + 1));
        end

        // Random request traffic on the minimum-timing instance; the monitor checks ordering.
        for (int k = 0; k < 400; k++) begin
            wake_b  = ($urandom_range(0, 5) == 0);
            sleep_b = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            #1;
        end
        wake_b = 1'b0; sleep_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pmu_pwr_seq.md
# pmu_pwr_seq

Power-domain sequencer for the shut-down domain, running on the always-on 32 kHz clock. Turns software wake/sleep requests into an ordered sequence of 13 MHz oscillator enable, shut-domain clock-gate enable (`clk_en`) and shut-domain reset release (`shut_rstn`). The outputs feed the clock/reset generation unit so that, on power-up, the 13M clock is stable before it is ungated and the shut-domain reset synchronisers see clock edges before release. On power-down, the reset is applied while the clock is still running.

## Interface
Parameters:
- `OSC_WAIT`, 8: cycles the oscillator is enabled before `clk_en` rises; range 1..255.
- `RST_HOLD`, 4: cycles `clk_en` is high before `shut_rstn` is released; range 1..255.
- `DRAIN`, 4: cycles `shut_rstn` is low with the clock running before `clk_en` falls; range 1..255.
- `CNT_W`, 8: width of the shared delay counter.

Ports:
- `clk` in 1: always-on 32 kHz clock.
- `rst` in 1: reset, synchronous, active-high.
- `wake_req` in 1: single-cycle wake request pulse.
- `sleep_req` in 1: single-cycle sleep request pulse.
- `osc13m_en` out 1: 13 MHz oscillator enable to the AD interface.
- `clk_en` out 1: shut-domain clock enable.
- `shut_rstn` out 1: shut-domain reset, active-low.
- `pwr_state` out 3: current FSM state encoding.
- `busy` out 1: a sequence is in progress (state is neither OFF nor ACTIVE).
- `seq_done` out 1: one-cycle pulse on entering ACTIVE or OFF, excluding entry due to reset.

## Operation
- Target register `tgt_on`, reset value 0:
  - `wake_req` sets it to 1.
  - `sleep_req` clears it to 0.
  - Both asserted in the same cycle: set to 1 (wake wins).
  - The FSM samples `tgt_on_nxt`, i.e. the request is visible in the same cycle it arrives.
- States and encodings: OFF=0, OSC_UP=1, CLK_ON=2, ACTIVE=3, RST_ON=4, CLK_OFF=5. Encodings 6 and 7 are illegal and go to OFF on the next edge with all outputs 0.
- OFF (osc=0, clk_en=0, shut_rstn=0): go to OSC_UP when `tgt_on_nxt`=1.
- OSC_UP (osc=1, clk_en=0, shut_rstn=0): stay OSC_WAIT cycles, then go to CLK_ON.
- CLK_ON (osc=1, clk_en=1, shut_rstn=0): stay RST_HOLD cycles, then go to ACTIVE.
- ACTIVE (osc=1, clk_en=1, shut_rstn=1): go to RST_ON when `tgt_on_nxt`=0. Minimum dwell is 1 cycle.
- RST_ON (osc=1, clk_en=1, shut_rstn=0): stay DRAIN cycles, then go to CLK_OFF.
- CLK_OFF (osc=1, clk_en=0, shut_rstn=0): stay 1 cycle, then go to OFF.
- Sequences are non-abortable. A request arriving mid-sequence only updates `tgt_on`, which is acted on at the next stable state (ACTIVE or OFF).
  - Example: sleep during OSC_UP → complete power-up → ACTIVE for 1 cycle → power-down.
  - Example: wake during RST_ON → complete power-down → OFF for 1 cycle → power-up.
- Delay counter:
  - One shared `CNT_W` counter, cleared on every state change.
  - Increments each cycle in timed states.
  - Leaves a state when count == N-1.
  - Never wraps; it is compared against a parameter that must be ≤ 2^CNT_W−1.
- All outputs are driven directly from flops updated on the same edge as the state register. No combinational decode reaches `clk_en`, `shut_rstn` or `osc13m_en`, because these feed clock-gate enables and reset synchronisers.

## Timing
- Reset values: `osc13m_en`=0, `clk_en`=0, `shut_rstn`=0, `pwr_state`=0, `busy`=0, `seq_done`=0, `tgt_on`=0, counter=0.
- Reset takes effect on the next `clk` edge with `rst`=1 from any state. No power-down sequence is run, and requests in that cycle are ignored.
- Power-up, with `wake_req` in cycle t and FSM in OFF:
  - `osc13m_en` rises at t+1.
  - `clk_en` rises at t+1+OSC_WAIT.
  - `shut_rstn` and `seq_done` rise at t+1+OSC_WAIT+RST_HOLD.
- Power-down, with `sleep_req` in cycle c and FSM in ACTIVE:
  - `shut_rstn` falls at c+1.
  - `clk_en` falls at c+1+DRAIN.
  - `osc13m_en` falls and `seq_done` pulses at c+2+DRAIN.
- Ordering invariants, checked every cycle:
  - `clk_en` ⇒ `osc13m_en`.
  - `shut_rstn` ⇒ `clk_en`.
  - `clk_en` never changes in the same cycle as `shut_rstn` or `osc13m_en`.
- `busy` is 1 in exactly the cycles where `pwr_state` ∈ {1,2,4,5}.

## Test plan
- Defaults, `rst` released, `wake_req` at cycle 0 → `osc13m_en`↑ at 1, `clk_en`↑ at 9, `shut_rstn`↑ at 13 with `seq_done`=1 for cycle 13 only, `busy`=1 for cycles 1–12.
- From ACTIVE, `sleep_req` at cycle 20 → `shut_rstn`↓ at 21, `clk_en`↓ at 25, `osc13m_en`↓ at 26, `pwr_state`=0 and `seq_done` pulse at 26.
- `sleep_req` at cycle 3 of power-up (wake at 0) → ACTIVE reached at 13 for exactly 1 cycle, `shut_rstn`↓ at 14, OFF at 19.
- `wake_req` during RST_ON → OFF for exactly 1 cycle, then OSC_UP; also `wake_req`+`sleep_req` together in OFF → power-up starts next cycle.
- `rst` asserted for 1 cycle while in CLK_ON → all outputs 0 and `pwr_state`=0 on the next edge, no `seq_done`, stays OFF without a new wake.
- Parameters OSC_WAIT=1, RST_HOLD=1, DRAIN=1 → up sequence and down sequence each take 3 cycles; ordering invariants asserted throughout a randomized request run.
